// File: rtl/serial_uart_pkg.sv
// Shared definitions for the serial UART bridge: FSM state encoding used by
// both the TX and RX paths, plus default sizing constants.
package serial_uart_pkg;

  // Common 2-bit state encoding for the TX serializer and RX deserializer.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } fsm_state_t;

  // 50 MHz system clock divided down to 115200 baud.
  localparam int DEFAULT_CLKS_PER_BIT = 434;
  localparam int DEFAULT_TX_DEPTH     = 4;
  localparam int BYTE_W               = 8;

endpackage

// File: rtl/serial_fifo.sv
// Parameterized synchronous FIFO with a combinational head read.
// Pushes while full and pops while empty are ignored, so the caller may
// leave the strobes raised without corrupting the pointers.
module serial_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Accept/consume decisions use the pre-edge full/empty flags, so a push
  // into a full FIFO is rejected even when a pop happens on the same edge.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign rd_data = mem[rd_ptr];

  // Storage array write.
  // NOTE: the data array is deliberately left out of reset; count/pointers
  // define which entries are valid, and a reset-free array maps onto RAM.
  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap modulo DEPTH.
  // NOTE: sequential state always uses non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/serial_uart.sv
// Byte-wide processor serial port to 8N1 UART bridge: TX FIFO feeding a
// serializer, and a deserializer feeding a one-byte holding register.
module serial_uart
  import serial_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int TX_DEPTH     = DEFAULT_TX_DEPTH
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [BYTE_W-1:0] wr_data_in,
  input  logic              wren_in,
  input  logic              rden_in,
  output logic [BYTE_W-1:0] rd_data_out,
  output logic              valid_out,
  output logic              ready_out,
  input  logic              uart_rx_in,
  output logic              uart_tx_out,
  output logic              rx_overrun_out,
  output logic              rx_frame_err_out
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int PTR_W = $clog2(TX_DEPTH);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [PTR_W:0]   TX_FULL_COUNT = (PTR_W + 1)'(TX_DEPTH);

  // ---------------------------------------------------------------- TX FIFO
  logic [BYTE_W-1:0] tx_head;
  logic              tx_full;
  logic              tx_empty;
  logic [PTR_W:0]    tx_count;
  logic              tx_push;
  logic              tx_pop;

  assign ready_out = (tx_count < TX_FULL_COUNT);
  assign tx_push   = wren_in && !tx_full;

  serial_fifo #(
    .WIDTH (BYTE_W),
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .clock   (clock),
    .reset   (reset),
    .push    (tx_push),
    .pop     (tx_pop),
    .wr_data (wr_data_in),
    .rd_data (tx_head),
    .full    (tx_full),
    .empty   (tx_empty),
    .count   (tx_count)
  );

  // ---------------------------------------------------------- TX serializer
  fsm_state_t        tx_state,  tx_state_n;
  logic [CNT_W-1:0]  tx_cnt,    tx_cnt_n;
  logic [2:0]        tx_bit,    tx_bit_n;
  logic [BYTE_W-1:0] tx_shift,  tx_shift_n;
  logic              tx_line,   tx_line_n;

  assign uart_tx_out = tx_line;

  // TX state register; the pin register resets high so reset idles the line.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tx_state <= ST_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      tx_line  <= 1'b1;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_bit   <= tx_bit_n;
      tx_shift <= tx_shift_n;
      tx_line  <= tx_line_n;
    end
  end

  // TX next-state: frame sequencing, FIFO pop and next pin level.
  // NOTE: every signal gets a default before the case so no path leaves a
  // variable unassigned, which would otherwise infer a latch.
  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt + 1'b1;
    tx_bit_n   = tx_bit;
    tx_shift_n = tx_shift;
    tx_line_n  = tx_line;
    tx_pop     = 1'b0;
    case (tx_state)
      ST_IDLE: begin
        tx_cnt_n  = '0;
        tx_line_n = 1'b1;
        if (!tx_empty) begin
          tx_pop     = 1'b1;
          tx_shift_n = tx_head;
          tx_state_n = ST_START;
          tx_line_n  = 1'b0;
        end
      end
      ST_START: begin
        if (tx_cnt == BIT_LAST) begin
          tx_cnt_n   = '0;
          tx_bit_n   = '0;
          tx_state_n = ST_DATA;
          tx_line_n  = tx_shift[0];
        end
      end
      ST_DATA: begin
        if (tx_cnt == BIT_LAST) begin
          tx_cnt_n = '0;
          if (tx_bit == 3'd7) begin
            tx_state_n = ST_STOP;
            tx_line_n  = 1'b1;
          end else begin
            tx_bit_n   = tx_bit + 1'b1;
            tx_shift_n = tx_shift >> 1;
            tx_line_n  = tx_shift[1];
          end
        end
      end
      ST_STOP: begin
        if (tx_cnt == BIT_LAST) begin
          tx_cnt_n = '0;
          // Chain straight into the next start bit when more data is queued.
          if (!tx_empty) begin
            tx_pop     = 1'b1;
            tx_shift_n = tx_head;
            tx_state_n = ST_START;
            tx_line_n  = 1'b0;
          end else begin
            tx_state_n = ST_IDLE;
            tx_line_n  = 1'b1;
          end
        end
      end
      default: begin
        tx_state_n = ST_IDLE;
        tx_line_n  = 1'b1;
      end
    endcase
  end

  // -------------------------------------------------------- RX deserializer
  logic              rx_s1;
  logic              rx_s2;
  fsm_state_t        rx_state,  rx_state_n;
  logic [CNT_W-1:0]  rx_cnt,    rx_cnt_n;
  logic [2:0]        rx_bit,    rx_bit_n;
  logic [BYTE_W-1:0] rx_shift,  rx_shift_n;
  logic              rx_deliver;
  logic              rx_bad_stop;

  // Two-flop synchronizer for the asynchronous pin; resets to the idle level.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
    end else begin
      rx_s1 <= uart_rx_in;
      rx_s2 <= rx_s1;
    end
  end

  // RX state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_state <= ST_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      rx_state <= rx_state_n;
      rx_cnt   <= rx_cnt_n;
      rx_bit   <= rx_bit_n;
      rx_shift <= rx_shift_n;
    end
  end

  // RX next-state: start validation at mid-bit, then one sample per bit time.
  always_comb begin
    rx_state_n  = rx_state;
    rx_cnt_n    = rx_cnt + 1'b1;
    rx_bit_n    = rx_bit;
    rx_shift_n  = rx_shift;
    rx_deliver  = 1'b0;
    rx_bad_stop = 1'b0;
    case (rx_state)
      ST_IDLE: begin
        rx_cnt_n = '0;
        rx_bit_n = '0;
        if (!rx_s2) begin
          rx_state_n = ST_START;
        end
      end
      ST_START: begin
        if (rx_cnt == HALF_LAST) begin
          rx_cnt_n   = '0;
          rx_bit_n   = '0;
          // A line that is high again at mid start bit was only a glitch.
          rx_state_n = rx_s2 ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (rx_cnt == BIT_LAST) begin
          rx_cnt_n   = '0;
          rx_shift_n = {rx_s2, rx_shift[BYTE_W-1:1]};
          rx_bit_n   = rx_bit + 1'b1;
          if (rx_bit == 3'd7) begin
            rx_state_n = ST_STOP;
          end
        end
      end
      ST_STOP: begin
        if (rx_cnt == BIT_LAST) begin
          rx_cnt_n    = '0;
          rx_state_n  = ST_IDLE;
          rx_deliver  = rx_s2;
          rx_bad_stop = !rx_s2;
        end
      end
      default: begin
        rx_state_n = ST_IDLE;
      end
    endcase
  end

  // Holding register toward the processor plus the one-cycle error pulses.
  // A read on the delivery cycle frees the slot, so the new byte is accepted.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_data_out      <= '0;
      valid_out        <= 1'b0;
      rx_overrun_out   <= 1'b0;
      rx_frame_err_out <= 1'b0;
    end else begin
      rx_overrun_out   <= 1'b0;
      rx_frame_err_out <= rx_bad_stop;
      if (rx_deliver) begin
        if (!valid_out || rden_in) begin
          rd_data_out <= rx_shift;
          valid_out   <= 1'b1;
        end else begin
          rx_overrun_out <= 1'b1;
        end
      end else if (rden_in) begin
        valid_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serial_uart.sv
// Directed self-checking bench for serial_uart with CLKS_PER_BIT=8, TX_DEPTH=4.
// Inputs change 1 ns after a rising edge; outputs are sampled at that point.
module tb_serial_uart;

  localparam int CPB   = 8;
  localparam int DEPTH = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] wr_data_in = 8'h00;
  logic       wren_in = 1'b0;
  logic       rden_in = 1'b0;
  logic       uart_rx_in = 1'b1;
  logic [7:0] rd_data_out;
  logic       valid_out;
  logic       ready_out;
  logic       uart_tx_out;
  logic       rx_overrun_out;
  logic       rx_frame_err_out;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  serial_uart #(
    .CLKS_PER_BIT (CPB),
    .TX_DEPTH     (DEPTH)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .wr_data_in       (wr_data_in),
    .wren_in          (wren_in),
    .rden_in          (rden_in),
    .rd_data_out      (rd_data_out),
    .valid_out        (valid_out),
    .ready_out        (ready_out),
    .uart_rx_in       (uart_rx_in),
    .uart_tx_out      (uart_tx_out),
    .rx_overrun_out   (rx_overrun_out),
    .rx_frame_err_out (rx_frame_err_out)
  );

  // Advance n rising edges and settle 1 ns past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] observed,
                       input logic [7:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Checks one TX frame. Called 'skip' edges after the start-bit edge S;
  // returns just after edge S+80, where the next frame (if any) begins.
  task automatic tx_frame(input string tag, input logic [7:0] b, input int skip);
    check($sformatf("%s start", tag), {7'd0, uart_tx_out}, 8'd0);
    step(7 - skip);
    check($sformatf("%s start end", tag), {7'd0, uart_tx_out}, 8'd0);
    for (int i = 0; i < 8; i++) begin
      step(1);
      check($sformatf("%s bit%0d first", tag, i), {7'd0, uart_tx_out}, {7'd0, b[i]});
      step(7);
      check($sformatf("%s bit%0d last", tag, i), {7'd0, uart_tx_out}, {7'd0, b[i]});
    end
    step(1);
    check($sformatf("%s stop", tag), {7'd0, uart_tx_out}, 8'd1);
    step(7);
    check($sformatf("%s stop end", tag), {7'd0, uart_tx_out}, 8'd1);
    step(1);
  endtask

  // Drives one RX frame starting 1 ns after edge F; returns 1 ns after F+77
  // with the line restored high (the stop sample is taken at edge F+79).
  task automatic rx_frame(input logic [7:0] b, input logic stop_bit);
    uart_rx_in = 1'b0;
    step(CPB);
    for (int i = 0; i < 8; i++) begin
      uart_rx_in = b[i];
      step(CPB);
    end
    uart_rx_in = stop_bit;
    step(5);
    uart_rx_in = 1'b1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic seen;

    // ---------------- reset values
    step(2);
    check("rst tx", {7'd0, uart_tx_out}, 8'd1);
    check("rst ready", {7'd0, ready_out}, 8'd1);
    check("rst valid", {7'd0, valid_out}, 8'd0);
    check("rst rd_data", rd_data_out, 8'h00);
    check("rst overrun", {7'd0, rx_overrun_out}, 8'd0);
    check("rst frame_err", {7'd0, rx_frame_err_out}, 8'd0);
    reset = 1'b0;
    step(2);
    check("post-rst tx", {7'd0, uart_tx_out}, 8'd1);

    // ---------------- single TX byte 0xA5, pushed at edge N
    wr_data_in = 8'hA5;
    wren_in    = 1'b1;
    step(1);
    wren_in = 1'b0;
    check("a5 tx at push edge", {7'd0, uart_tx_out}, 8'd1);
    step(1);
    tx_frame("a5", 8'hA5, 0);
    check("a5 idle after frame", {7'd0, uart_tx_out}, 8'd1);
    step(10);
    check("a5 still idle", {7'd0, uart_tx_out}, 8'd1);

    // ---------------- TX full: six pushes, 0x06 dropped
    for (int k = 0; k < 6; k++) begin
      wr_data_in = 8'(k + 1);
      wren_in    = 1'b1;
      step(1);
      if (k == 3) check("ready before fill", {7'd0, ready_out}, 8'd1);
      if (k == 4) check("ready at fill", {7'd0, ready_out}, 8'd0);
      if (k == 5) check("ready after drop", {7'd0, ready_out}, 8'd0);
    end
    wren_in = 1'b0;
    tx_frame("f01", 8'h01, 4);
    check("ready after pop", {7'd0, ready_out}, 8'd1);
    tx_frame("f02", 8'h02, 0);
    tx_frame("f03", 8'h03, 0);
    tx_frame("f04", 8'h04, 0);
    tx_frame("f05", 8'h05, 0);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (uart_tx_out !== 1'b1) seen = 1'b1;
      step(1);
    end
    check("no 0x06 frame", {7'd0, seen}, 8'd0);

    // ---------------- RX byte 0x3C
    step(3);
    rx_frame(8'h3C, 1'b1);
    check("3c valid early", {7'd0, valid_out}, 8'd0);
    step(1);
    check("3c valid F+78", {7'd0, valid_out}, 8'd0);
    step(1);
    check("3c valid", {7'd0, valid_out}, 8'd1);
    check("3c data", rd_data_out, 8'h3C);
    rden_in = 1'b1;
    step(1);
    rden_in = 1'b0;
    check("3c cleared", {7'd0, valid_out}, 8'd0);
    rden_in = 1'b1;
    step(1);
    rden_in = 1'b0;
    check("idle read ignored", {7'd0, valid_out}, 8'd0);

    // ---------------- overrun
    step(3);
    rx_frame(8'h11, 1'b1);
    step(2);
    check("11 valid", {7'd0, valid_out}, 8'd1);
    check("11 data", rd_data_out, 8'h11);
    step(3);
    rx_frame(8'h22, 1'b1);
    step(2);
    check("ovr pulse", {7'd0, rx_overrun_out}, 8'd1);
    check("ovr keeps old", rd_data_out, 8'h11);
    check("ovr valid", {7'd0, valid_out}, 8'd1);
    step(1);
    check("ovr one cycle", {7'd0, rx_overrun_out}, 8'd0);

    // ---------------- delivery with same-cycle read
    step(3);
    rx_frame(8'h22, 1'b1);
    step(1);
    rden_in = 1'b1;
    step(1);
    rden_in = 1'b0;
    check("same-cycle data", rd_data_out, 8'h22);
    check("same-cycle valid", {7'd0, valid_out}, 8'd1);
    check("same-cycle no ovr", {7'd0, rx_overrun_out}, 8'd0);
    step(1);
    check("same-cycle no ovr later", {7'd0, rx_overrun_out}, 8'd0);
    rden_in = 1'b1;
    step(1);
    rden_in = 1'b0;
    check("22 cleared", {7'd0, valid_out}, 8'd0);

    // ---------------- 2-cycle glitch
    step(3);
    uart_rx_in = 1'b0;
    step(2);
    uart_rx_in = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step(1);
      if (valid_out !== 1'b0 || rx_frame_err_out !== 1'b0) seen = 1'b1;
    end
    check("glitch no output", {7'd0, seen}, 8'd0);

    // ---------------- frame error on 0x55 with low stop bit
    rx_frame(8'h55, 1'b0);
    step(2);
    check("ferr pulse", {7'd0, rx_frame_err_out}, 8'd1);
    check("ferr no valid", {7'd0, valid_out}, 8'd0);
    step(1);
    check("ferr one cycle", {7'd0, rx_frame_err_out}, 8'd0);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step(1);
      if (valid_out !== 1'b0 || rx_frame_err_out !== 1'b0) seen = 1'b1;
    end
    check("ferr no aftermath", {7'd0, seen}, 8'd0);

    // ---------------- reset during TX bit 3 with two bytes queued
    for (int k = 0; k < 3; k++) begin
      wr_data_in = 8'h81 + 8'(k);
      wren_in    = 1'b1;
      step(1);
    end
    wren_in = 1'b0;
    step(34);
    check("bit3 before reset", {7'd0, uart_tx_out}, 8'd0);
    check("queued before reset", {7'd0, ready_out}, 8'd1);
    reset = 1'b1;
    #1;
    check("async rst tx", {7'd0, uart_tx_out}, 8'd1);
    check("async rst ready", {7'd0, ready_out}, 8'd1);
    step(2);
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      step(1);
      if (uart_tx_out !== 1'b1) seen = 1'b1;
    end
    check("no tx after reset", {7'd0, seen}, 8'd0);
    check("ready after reset", {7'd0, ready_out}, 8'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
